uart_memory_controller: RTL and testbench

Byte-command memory controller between a UART receiver and a UART transmitter. It parses a byte stream of write and read commands, stores data in an internal byte-wide RAM, and returns read data as a single byte for transmission. It sits directly behind the UART RX strobe and in front of the UART TX request.

---
 rtl/uart_memory_pkg.sv | 14 +
 rtl/byte_ram.sv | 21 ++
 rtl/uart_memory_controller.sv | 106 ++++++++++
 tb/tb_uart_memory_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_memory_pkg.sv
// Shared command codes and parser state encoding for the UART memory controller.
package uart_memory_pkg;

  localparam logic [7:0] COMMAND_WRITE = 8'h57;
  localparam logic [7:0] COMMAND_READ  = 8'h52;

  typedef enum logic [1:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA
  } state_e;

endpackage

// File: rtl/byte_ram.sv
// Single-port byte RAM with registered read data (one-cycle latency), block-RAM inferable.
module byte_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/uart_memory_controller.sv
// Parses W/R byte commands from the UART receiver, accesses the byte RAM and
// hands read data to the UART transmitter as a one-cycle transmit pulse.
module uart_memory_controller
  import uart_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       received,
  input  logic [7:0] rx_byte,
  output logic       transmit,
  output logic [7:0] tx_byte
);

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic            read_pending_q, read_pending_d;
  logic            transmit_q;
  logic [7:0]      tx_byte_q;
  logic [7:0]      addr_hi_q, addr_lo_q;

  logic                  ram_we;
  logic [15:0]           full_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_rdata;

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    read_pending_d = 1'b0;
    ram_we         = 1'b0;
    // Reads use the live low byte so RAM data is ready one edge after ADDR_LO.
    full_addr      = {addr_hi_q, rx_byte};
    if (received) begin
      unique case (state_q)
        IDLE: begin
          if (rx_byte == COMMAND_WRITE) begin
            write_d = 1'b1;
            state_d = ADDR_HI;
          end else if (rx_byte == COMMAND_READ) begin
            write_d = 1'b0;
            state_d = ADDR_HI;
          end
        end
        ADDR_HI: state_d = ADDR_LO;
        ADDR_LO: begin
          if (write_q) begin
            state_d = DATA;
          end else begin
            read_pending_d = 1'b1;
            state_d        = IDLE;
          end
        end
        DATA: begin
          ram_we    = 1'b1;
          full_addr = {addr_hi_q, addr_lo_q};
          state_d   = IDLE;
        end
      endcase
    end
    ram_addr = ADDR_WIDTH'(full_addr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      read_pending_q <= 1'b0;
      transmit_q     <= 1'b0;
      tx_byte_q      <= 8'h00;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      read_pending_q <= read_pending_d;
      transmit_q     <= read_pending_q;
      if (read_pending_q) begin
        tx_byte_q <= ram_rdata;
      end
    end
  end

  // Address bytes are pure data; a reset returns the parser to IDLE so stale values are harmless.
  always_ff @(posedge clock) begin
    if (received && state_q == ADDR_HI) begin
      addr_hi_q <= rx_byte;
    end
    if (received && state_q == ADDR_LO) begin
      addr_lo_q <= rx_byte;
    end
  end

  byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(rx_byte),
    .rdata(ram_rdata)
  );

  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_memory_controller.sv
// Bench for uart_memory_controller: directed scenarios plus random command traffic
// checked against a byte-array memory model and an expected-transmit queue.
module tb_uart_memory_controller;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       transmit;
  logic [7:0] tx_byte;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] mem_m [int];
  int         wr_addrs [$];

  uart_memory_controller #(.ADDR_WIDTH(AW)) dut (
    .clock   (clock),
    .reset   (reset),
    .received(received),
    .rx_byte (rx_byte),
    .transmit(transmit),
    .tx_byte (tx_byte)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Every transmit pulse must match the oldest outstanding read, on its predicted cycle.
  always @(negedge clock) begin
    if (transmit === 1'b1) begin
      exp_t e;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL tx_unexpected: got pulse with tx_byte=%h expected no pulse", tx_byte);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (tx_byte === e.data) else begin
          errors++;
          $error("FAIL tx_data: got %h expected %h", tx_byte, e.data);
        end
        checks++;
        assert (cyc === e.cyc) else begin
          errors++;
          $error("FAIL tx_timing: got cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a falling edge; one strobe, then gap idle cycles.
  task automatic put(input logic [7:0] b, input int gap);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clock);
    received = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap);
    int key;
    key = int'(a) % DEPTH;
    put(8'h57, gap);
    put(a[15:8], gap);
    put(a[7:0], gap);
    put(d, gap);
    if (!mem_m.exists(key)) wr_addrs.push_back(key);
    mem_m[key] = d;
  endtask

  task automatic do_read(input logic [15:0] a, input int gap);
    int key;
    key = int'(a) % DEPTH;
    put(8'h52, gap);
    put(a[15:8], gap);
    exp_q.push_back('{data: mem_m[key], cyc: cyc + 2});
    put(a[7:0], gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (transmit === 1'b0) else begin
      errors++;
      $error("FAIL %s_transmit: got %b expected 0", tag, transmit);
    end
    checks++;
    assert (tx_byte === 8'h00) else begin
      errors++;
      $error("FAIL %s_tx_byte: got %h expected 00", tag, tx_byte);
    end
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] a;
    logic [7:0]  junk;
    int          gap;

    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("post_por");

    // Writes then reads with one idle cycle between strobes
    do_write(16'h0ECD, 8'h42, 1);
    do_write(16'h0A10, 8'h44, 1);
    do_read(16'h0ECD, 1);
    do_read(16'h0A10, 1);

    // Back-to-back strobes, read directly after write
    do_write(16'h0102, 8'h5A, 0);
    do_read(16'h0102, 0);
    repeat (3) @(negedge clock);

    // Unknown command bytes are ignored
    put(8'h00, 1);
    put(8'hFF, 1);
    do_read(16'h0ECD, 1);

    // Upper address bits alias onto the same location
    do_write(16'hFECD, 8'h99, 1);
    do_read(16'h0ECD, 1);
    do_write(16'h0ECD, 8'h42, 1);

    // Reset before the DATA byte aborts the write
    put(8'h57, 0);
    put(8'h0E, 0);
    put(8'hCD, 0);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_cmd_rst");
    repeat (2) @(negedge clock);
    check_reset_outputs("mid_cmd_rst_hold");
    reset = 1'b0;
    @(negedge clock);
    put(8'h77, 1);
    do_read(16'h0ECD, 1);
    repeat (3) @(negedge clock);

    // Reset in the cycle after ADDR_LO cancels the pending transmit
    put(8'h52, 0);
    put(8'h0E, 0);
    put(8'hCD, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_outputs("lat_rst");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("lat_rst_after");

    // Random traffic: writes, reads of written locations, junk bytes, random gaps
    for (int i = 0; i < 80; i++) begin
      gap = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0, 1: begin
          a = 16'($urandom_range(0, 65535));
          d = 8'($urandom);
          do_write(a, d, gap);
        end
        2: begin
          a = 16'(($urandom_range(0, 65535) & ~(DEPTH - 1))
                  | wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
          do_read(a, gap);
        end
        default: begin
          junk = 8'($urandom);
          if (junk != 8'h57 && junk != 8'h52) put(junk, gap);
        end
      endcase
    end

    repeat (5) @(negedge clock);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL missing_tx: got %0d reads without a pulse expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
